mem_stage_lsu: RTL

Memory-stage load/store unit that consumes the EX/MEM pipeline register outputs. It performs each load or store as a req/gnt/rvalid transaction on the data bus and stalls the pipeline until the access completes. For loads it steers byte lanes, sign- or zero-extends the data by funct3, and presents the result to the MEM/WB register. Misaligned and illegal accesses are flagged and never issued to the bus.

---
 rtl/mem_stage_lsu_pkg.sv | 24 ++
 rtl/mem_stage_lsu_align.sv | 81 ++++++++
 rtl/mem_stage_lsu.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/mem_stage_lsu_pkg.sv
// Shared constants and types for the memory-stage load/store unit.
// Holds the opcode and funct3 encodings and the LSU state enum.
package mem_stage_lsu_pkg;

   localparam int WIDTH     = 32;
   localparam int NUM_LANES = 4;

   localparam logic [6:0] OPC_LOAD  = 7'b0000011;
   localparam logic [6:0] OPC_STORE = 7'b0100011;

   localparam logic [2:0] F3_LB  = 3'b000;
   localparam logic [2:0] F3_LH  = 3'b001;
   localparam logic [2:0] F3_LW  = 3'b010;
   localparam logic [2:0] F3_LBU = 3'b100;
   localparam logic [2:0] F3_LHU = 3'b101;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      RESP = 2'd2,
      DONE = 2'd3
   } lsu_state_t;

endpackage

// File: rtl/mem_stage_lsu_align.sv
// Byte-lane steering for the LSU: store byte enables and replicated write
// data, load extraction with sign/zero extension, and legality check.
module lsu_align
   import mem_stage_lsu_pkg::*;
(
   input  logic [2:0]       funct3,
   input  logic             is_store,
   input  logic [1:0]       addr_lo,
   input  logic [WIDTH-1:0] rs2,
   input  logic [WIDTH-1:0] rdata,
   output logic [3:0]       be,
   output logic [WIDTH-1:0] wdata,
   output logic [WIDTH-1:0] load_data,
   output logic             bad
);

   logic       legal_s;
   logic       misalign_s;
   logic [7:0] byte_s;
   logic [15:0] half_s;

   // legality of funct3 for the access direction, plus natural alignment
   always_comb begin
      legal_s    = 1'b0;
      misalign_s = 1'b0;
      if (is_store) begin
         legal_s = (funct3 == F3_LB) || (funct3 == F3_LH) || (funct3 == F3_LW);
      end else begin
         legal_s = (funct3 == F3_LB) || (funct3 == F3_LH) || (funct3 == F3_LW) ||
                   (funct3 == F3_LBU) || (funct3 == F3_LHU);
      end
      case (funct3[1:0])
         2'b01:   misalign_s = addr_lo[0];
         2'b10:   misalign_s = (addr_lo != 2'b00);
         default: misalign_s = 1'b0;
      endcase
      bad = !legal_s || misalign_s;
   end

   // store lane enables and lane-replicated data
   always_comb begin
      be    = 4'b0000;
      wdata = rs2;
      case (funct3[1:0])
         2'b00: begin
            be    = 4'b0001 << addr_lo;
            wdata = {4{rs2[7:0]}};
         end
         2'b01: begin
            be    = addr_lo[1] ? 4'b1100 : 4'b0011;
            wdata = {2{rs2[15:0]}};
         end
         default: begin
            be    = 4'b1111;
            wdata = rs2;
         end
      endcase
   end

   // load lane extraction and extension
   always_comb begin
      byte_s    = 8'h00;
      half_s    = addr_lo[1] ? rdata[31:16] : rdata[15:0];
      load_data = rdata;
      case (addr_lo)
         2'b00:   byte_s = rdata[7:0];
         2'b01:   byte_s = rdata[15:8];
         2'b10:   byte_s = rdata[23:16];
         2'b11:   byte_s = rdata[31:24];
         default: byte_s = 8'h00;
      endcase
      case (funct3)
         F3_LB:   load_data = {{24{byte_s[7]}}, byte_s};
         F3_LH:   load_data = {{16{half_s[15]}}, half_s};
         F3_LBU:  load_data = {24'h000000, byte_s};
         F3_LHU:  load_data = {16'h0000, half_s};
         default: load_data = rdata;
      endcase
   end

endmodule

// File: rtl/mem_stage_lsu.sv
// Memory-stage LSU: issues loads/stores as req/gnt/rvalid bus transactions,
// stalls the pipeline while an access is in flight, and formats load data.
module mem_stage_lsu
   import mem_stage_lsu_pkg::*;
(
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] mem_alu_result,
   input  logic [WIDTH-1:0] mem_reg_data2,
   input  logic [2:0]       mem_funct3,
   input  logic [6:0]       mem_opcode,
   input  logic             mem_mem_wr_en,
   output logic             dbus_req,
   output logic             dbus_we,
   output logic [WIDTH-1:0] dbus_addr,
   output logic [3:0]       dbus_be,
   output logic [WIDTH-1:0] dbus_wdata,
   input  logic             dbus_gnt,
   input  logic             dbus_rvalid,
   input  logic [WIDTH-1:0] dbus_rdata,
   output logic             lsu_stall,
   output logic [WIDTH-1:0] wb_load_data,
   output logic             misalign_err
);

   lsu_state_t       state_r;
   lsu_state_t       next_state_s;
   logic [2:0]       funct3_r;
   logic             is_load_s;
   logic             is_store_s;
   logic             mem_op_s;
   logic             accept_s;
   logic [2:0]       align_f3_s;
   logic [1:0]       align_lo_s;
   logic [3:0]       be_s;
   logic [WIDTH-1:0] wdata_s;
   logic [WIDTH-1:0] load_data_s;
   logic             bad_s;

   assign is_load_s  = (mem_opcode == OPC_LOAD);
   assign is_store_s = (mem_opcode == OPC_STORE) && mem_mem_wr_en;
   assign mem_op_s   = is_load_s || is_store_s;
   assign accept_s   = (state_r == IDLE) && mem_op_s && !bad_s;

   // In IDLE the aligner looks at the incoming op; afterwards at the latched request.
   assign align_f3_s = (state_r == IDLE) ? mem_funct3 : funct3_r;
   assign align_lo_s = (state_r == IDLE) ? mem_alu_result[1:0] : dbus_addr[1:0];

   lsu_align u_align (
      .funct3    (align_f3_s),
      .is_store  (is_store_s),
      .addr_lo   (align_lo_s),
      .rs2       (mem_reg_data2),
      .rdata     (dbus_rdata),
      .be        (be_s),
      .wdata     (wdata_s),
      .load_data (load_data_s),
      .bad       (bad_s)
   );

   // state register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r <= IDLE;
      end else begin
         state_r <= next_state_s;
      end
   end

   // next-state logic; stray gnt/rvalid outside REQ/RESP have no effect
   always_comb begin
      next_state_s = state_r;
      case (state_r)
         IDLE: begin
            if (accept_s) next_state_s = REQ;
            else          next_state_s = IDLE;
         end
         REQ: begin
            if (dbus_gnt) next_state_s = dbus_we ? DONE : RESP;
            else          next_state_s = REQ;
         end
         RESP: begin
            if (dbus_rvalid) next_state_s = DONE;
            else             next_state_s = RESP;
         end
         DONE:    next_state_s = IDLE;
         default: next_state_s = IDLE;
      endcase
   end

   // request registers, held stable from acceptance until the next accepted op
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         dbus_req   <= 1'b0;
         dbus_we    <= 1'b0;
         dbus_addr  <= {WIDTH{1'b0}};
         dbus_be    <= 4'b0000;
         dbus_wdata <= {WIDTH{1'b0}};
         funct3_r   <= 3'b000;
      end else begin
         dbus_req <= (next_state_s == REQ);
         if (accept_s) begin
            dbus_we    <= is_store_s;
            dbus_addr  <= mem_alu_result;
            dbus_be    <= be_s;
            dbus_wdata <= wdata_s;
            funct3_r   <= mem_funct3;
         end else begin
            dbus_we    <= dbus_we;
            dbus_addr  <= dbus_addr;
            dbus_be    <= dbus_be;
            dbus_wdata <= dbus_wdata;
            funct3_r   <= funct3_r;
         end
      end
   end

   // load result capture
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wb_load_data <= {WIDTH{1'b0}};
      end else if ((state_r == RESP) && dbus_rvalid) begin
         wb_load_data <= load_data_s;
      end else begin
         wb_load_data <= wb_load_data;
      end
   end

   // stall and reject flags, both forced low while reset is asserted
   always_comb begin
      lsu_stall    = 1'b0;
      misalign_err = 1'b0;
      if (rst) begin
         lsu_stall    = 1'b0;
         misalign_err = 1'b0;
      end else begin
         case (state_r)
            IDLE: begin
               lsu_stall    = mem_op_s && !bad_s;
               misalign_err = mem_op_s && bad_s;
            end
            REQ:     lsu_stall = 1'b1;
            RESP:    lsu_stall = 1'b1;
            default: lsu_stall = 1'b0;
         endcase
      end
   end

endmodule
